// File: rtl/p251_inv_if.sv
// Start/done handshake and operand/result bus for the GF(251) inverse unit.
interface p251_inv_if;
    logic       i_start;
    logic [7:0] in_1;
    logic [7:0] out;
    logic       o_done;
    logic       o_busy;

    modport master (output i_start, output in_1, input out, input o_done, input o_busy);
    modport slave  (input i_start, input in_1, output out, output o_done, output o_busy);
endinterface

// File: rtl/p251_inv.sv
// GF(251) multiplicative inverse by Fermat exponentiation: out = in_1^249 mod 251.
// One modular multiply per cycle, 16 square/multiply steps per operand.
module p251_inv (
    input  logic         i_clk,
    input  logic         i_rst,
    p251_inv_if.slave    bus
);
    localparam int unsigned W   = 8;
    localparam int unsigned KW  = 4;
    localparam logic [W-1:0] MOD = 8'd251;
    localparam logic [W-1:0] EXP = 8'b1111_1001;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  out_q, out_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic [2:0]    bit_idx;
    logic [W-1:0]  mul_y;
    logic [W-1:0]  mul_res;
    logic [W-1:0]  in_red;

    // x*y mod 251 using 256 = 5 (mod 251) folded twice, then one conditional subtract.
    function automatic logic [W-1:0] mod_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [15:0] p;
        logic [10:0] t1;
        logic [8:0]  t2;
        p  = 16'(x) * 16'(y);
        t1 = 11'(p[15:8]) * 11'd5 + 11'(p[7:0]);
        t2 = 9'(t1[10:8]) * 9'd5 + 9'(t1[7:0]);
        if (t2 >= 9'(MOD)) begin
            mod_mul = 8'(t2 - 9'(MOD));
        end else begin
            mod_mul = t2[7:0];
        end
    endfunction

    // Even steps square, odd steps multiply by a when the exponent bit is set.
    always_comb begin
        bit_idx = ~k_q[3:1];
        if (k_q[0]) begin
            mul_y = EXP[bit_idx] ? a_q : 8'd1;
        end else begin
            mul_y = acc_q;
        end
        mul_res = mod_mul(acc_q, mul_y);
        in_red  = (bus.in_1 >= MOD) ? 8'(bus.in_1 - MOD) : bus.in_1;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        acc_d   = acc_q;
        k_d     = k_q;
        out_d   = out_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.i_start) begin
                    a_d     = in_red;
                    acc_d   = 8'd1;
                    k_d     = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                acc_d = mul_res;
                k_d   = k_q + 4'd1;
                if (k_q == 4'd15) begin
                    out_d   = mul_res;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.out    = out_q;
    assign bus.o_done = done_q;
    assign bus.o_busy = busy_q;
endmodule

// File: tb/tb_p251_inv.sv
// Directed self-checking bench for the GF(251) inverse unit.
module tb_p251_inv;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    p251_inv_if bus ();

    p251_inv dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Capture v, then wait (bounded) for the done pulse; lat counts edges after capture.
    task automatic run_op(input logic [7:0] v, output logic [7:0] res, output int lat);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.in_1    = v;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.in_1    = ~v;
        lat = 0;
        while (bus.o_done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = bus.out;
    endtask

    initial begin
        logic [7:0] res;
        int         lat;
        int         n;
        int         seen;
        logic [7:0] kv_in  [4];
        logic [7:0] kv_out [4];
        logic [7:0] bd_in  [3];
        logic [7:0] bd_out [3];

        checks = 0;
        errors = 0;
        kv_in  = '{8'd1, 8'd3, 8'd20, 8'd250};
        kv_out = '{8'd1, 8'd84, 8'd113, 8'd250};
        bd_in  = '{8'd0, 8'd252, 8'd255};
        bd_out = '{8'd0, 8'd1, 8'd63};

        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.in_1    = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 32'(bus.out), 32'd0);
        check("reset_done", 32'(bus.o_done), 32'd0);
        check("reset_busy", 32'(bus.o_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'd2, res, lat);
        check("inv2_out", 32'(res), 32'd126);
        check("inv2_lat", 32'(lat), 32'd16);
        check("inv2_busy_in_done", 32'(bus.o_busy), 32'd1);
        @(posedge clk);
        #1;
        check("inv2_done_pulse", 32'(bus.o_done), 32'd0);
        check("inv2_busy_fall", 32'(bus.o_busy), 32'd0);
        check("inv2_out_hold", 32'(bus.out), 32'd126);

        for (int i = 0; i < 4; i++) begin
            run_op(kv_in[i], res, lat);
            check($sformatf("known_%0d_out", kv_in[i]), 32'(res), 32'(kv_out[i]));
            check($sformatf("known_%0d_lat", kv_in[i]), 32'(lat), 32'd16);
        end

        for (int i = 0; i < 3; i++) begin
            run_op(bd_in[i], res, lat);
            check($sformatf("bound_%0d_out", bd_in[i]), 32'(res), 32'(bd_out[i]));
            check($sformatf("bound_%0d_lat", bd_in[i]), 32'(lat), 32'd16);
        end

        for (int v = 1; v <= 250; v++) begin
            run_op(8'(v), res, lat);
            check($sformatf("sweep_%0d_prod", v), 32'((v * int'(res)) % 251), 32'd1);
            check($sformatf("sweep_%0d_lat", v), 32'(lat), 32'd16);
        end

        // Start ignored while busy, then back-to-back capture during DONE.
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.in_1    = 8'd20;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.in_1    = 8'd0;
        lat = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bus.i_start = 1'b1;
        bus.in_1    = 8'd3;
        @(posedge clk);
        #1;
        lat++;
        bus.i_start = 1'b0;
        check("busy_during_run", 32'(bus.o_busy), 32'd1);
        while (bus.o_done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("ignore_start_out", 32'(bus.out), 32'd113);
        check("ignore_start_lat", 32'(lat), 32'd16);
        bus.i_start = 1'b1;
        bus.in_1    = 8'd3;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.in_1    = 8'd7;
        check("b2b_done_drop", 32'(bus.o_done), 32'd0);
        check("b2b_busy_stay", 32'(bus.o_busy), 32'd1);
        check("b2b_out_hold", 32'(bus.out), 32'd113);
        n = 1;
        while (bus.o_done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_out", 32'(bus.out), 32'd84);
        check("b2b_spacing", 32'(n), 32'd17);
        @(posedge clk);
        #1;
        check("b2b_idle_busy", 32'(bus.o_busy), 32'd0);

        // Reset in the middle of a computation aborts without a done pulse.
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.in_1    = 8'd2;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out", 32'(bus.out), 32'd0);
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        check("abort_done", 32'(bus.o_done), 32'd0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 2) rst = 1'b0;
            if (bus.o_done === 1'b1) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        check("abort_idle_busy", 32'(bus.o_busy), 32'd0);

        run_op(8'd250, res, lat);
        check("post_reset_out", 32'(res), 32'd250);
        check("post_reset_lat", 32'(lat), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
